// File: rtl/sat_check_seq.sv
// Sequential CNF clause checker: snapshots a clause database and a partial
// assignment on start, scans one clause per clock, reports SAT / conflict / first unit.
module sat_check_seq #(
  parameter int MAX_CLAUSES     = 16,
  parameter int LITS_PER_CLAUSE = 3,
  parameter int NUM_VARS        = 8,
  parameter int VAR_W           = 3,
  localparam int LIT_W = VAR_W + 2,
  localparam int CNT_W = $clog2(MAX_CLAUSES + 1),
  localparam int IDX_W = $clog2(MAX_CLAUSES)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [MAX_CLAUSES*LITS_PER_CLAUSE*LIT_W-1:0] clauses,
  input  logic [MAX_CLAUSES-1:0]                     clause_valid,
  input  logic [NUM_VARS-1:0]                        assign_def,
  input  logic [NUM_VARS-1:0]                        assign_val,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       return_true,
  output logic                                       return_false,
  output logic                                       unit_found,
  output logic [VAR_W:0]                             unit_lit,
  output logic [IDX_W-1:0]                           unit_clause,
  output logic [CNT_W-1:0]                           sat_count
);

  localparam int VAR_SPAN = 1 << VAR_W;
  localparam int DB_W     = MAX_CLAUSES * LITS_PER_CLAUSE * LIT_W;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state, state_next;

  logic [DB_W-1:0]        snap_clauses;
  logic [MAX_CLAUSES-1:0] snap_valid;
  logic [VAR_SPAN-1:0]    snap_def;
  logic [VAR_SPAN-1:0]    snap_val;

  logic [IDX_W-1:0] scan_idx;
  logic             all_sat;
  logic             accept;
  logic             scan_last;

  logic             cls_valid;
  logic             any_true;
  logic             unres_one;
  logic             unres_many;
  logic [VAR_W:0]   unres_lit;
  logic [LIT_W-1:0] lit;
  logic             is_sat;
  logic             is_conflict;
  logic             is_unit;
  logic             cls_unsat;

  assign accept    = (state == IDLE) && start;
  assign scan_last = (scan_idx == IDX_W'(MAX_CLAUSES - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (is_conflict || scan_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state == SCAN);
  end

  // NOTE: the snapshot is pure data qualified by the FSM, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      snap_clauses <= clauses;
      snap_valid   <= clause_valid;
      snap_def     <= VAR_SPAN'(assign_def);
      snap_val     <= VAR_SPAN'(assign_val);
    end
  end

  // Classify the clause under the scan pointer. Indices >= NUM_VARS are inactive,
  // which also keeps the zero-padded upper assignment bits from ever being used.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    any_true   = 1'b0;
    unres_one  = 1'b0;
    unres_many = 1'b0;
    unres_lit  = '0;
    lit        = '0;
    for (int k = 0; k < LITS_PER_CLAUSE; k++) begin
      lit = snap_clauses[(int'(scan_idx) * LITS_PER_CLAUSE + k) * LIT_W +: LIT_W];
      if (lit[LIT_W-1] && (int'(lit[VAR_W-1:0]) < NUM_VARS)) begin
        if (snap_def[lit[VAR_W-1:0]]) begin
          if (snap_val[lit[VAR_W-1:0]] ^ lit[LIT_W-2]) any_true = 1'b1;
        end else begin
          unres_many = unres_many | unres_one;
          unres_one  = 1'b1;
          unres_lit  = lit[VAR_W:0];
        end
      end
    end
  end

  assign cls_valid   = snap_valid[scan_idx];
  assign is_sat      = cls_valid & any_true;
  assign cls_unsat   = cls_valid & ~any_true;
  assign is_conflict = cls_unsat & ~unres_one;
  assign is_unit     = cls_unsat & unres_one & ~unres_many;

  // ---------------- scan datapath and held results ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx     <= '0;
      all_sat      <= 1'b0;
      done         <= 1'b0;
      return_true  <= 1'b0;
      return_false <= 1'b0;
      unit_found   <= 1'b0;
      unit_lit     <= '0;
      unit_clause  <= '0;
      sat_count    <= '0;
    end else if (accept) begin
      scan_idx     <= '0;
      all_sat      <= 1'b1;
      done         <= 1'b0;
      return_true  <= 1'b0;
      return_false <= 1'b0;
      unit_found   <= 1'b0;
      unit_lit     <= '0;
      unit_clause  <= '0;
      sat_count    <= '0;
    end else if (state == SCAN) begin
      done     <= is_conflict || scan_last;
      all_sat  <= all_sat & ~cls_unsat;
      scan_idx <= scan_idx + IDX_W'(1);
      if (is_sat) sat_count <= sat_count + CNT_W'(1);
      // Only the lowest-index unit clause is reported.
      if (is_unit && !unit_found) begin
        unit_found  <= 1'b1;
        unit_lit    <= unres_lit;
        unit_clause <= scan_idx;
      end
      if (is_conflict)    return_false <= 1'b1;
      else if (scan_last) return_true  <= all_sat & ~cls_unsat;
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sat_check_seq.sv
// Scoreboard bench for sat_check_seq: two instances (NUM_VARS=4 and NUM_VARS=3)
// share stimulus; a spec-level reference model predicts each verdict and its timing.
module tb_sat_check_seq;

  localparam int MC  = 4;
  localparam int LPC = 3;
  localparam int VW  = 2;
  localparam int LW  = VW + 2;
  localparam int DBW = MC * LPC * LW;

  typedef struct packed {
    int         done_cyc;
    logic       rt;
    logic       rf;
    logic       uf;
    logic [2:0] ul;
    logic [1:0] uc;
    logic [2:0] sc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [DBW-1:0] clauses = '0;
  logic [MC-1:0]  valid = '0;
  logic [3:0]     def = '0;
  logic [3:0]     val = '0;

  logic       busy_w[2];
  logic       done_w[2];
  logic       rt_w[2];
  logic       rf_w[2];
  logic       uf_w[2];
  logic [2:0] ul_w[2];
  logic [1:0] uc_w[2];
  logic [2:0] sc_w[2];

  sat_check_seq #(.MAX_CLAUSES(MC), .LITS_PER_CLAUSE(LPC), .NUM_VARS(4), .VAR_W(VW)) dut4 (
    .clk(clk), .rst(rst), .start(start), .clauses(clauses), .clause_valid(valid),
    .assign_def(def), .assign_val(val), .busy(busy_w[0]), .done(done_w[0]),
    .return_true(rt_w[0]), .return_false(rf_w[0]), .unit_found(uf_w[0]),
    .unit_lit(ul_w[0]), .unit_clause(uc_w[0]), .sat_count(sc_w[0]));

  sat_check_seq #(.MAX_CLAUSES(MC), .LITS_PER_CLAUSE(LPC), .NUM_VARS(3), .VAR_W(VW)) dut3 (
    .clk(clk), .rst(rst), .start(start), .clauses(clauses), .clause_valid(valid),
    .assign_def(def[2:0]), .assign_val(val[2:0]), .busy(busy_w[1]), .done(done_w[1]),
    .return_true(rt_w[1]), .return_false(rf_w[1]), .unit_found(uf_w[1]),
    .unit_lit(ul_w[1]), .unit_clause(uc_w[1]), .sat_count(sc_w[1]));

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t hold_e[2];
  int   acc_e[2];
  int   end_e[2];
  int   free_e[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference: classify each valid clause from literal counts, stop at the first conflict.
  function automatic exp_t model(input logic [DBW-1:0] cl, input logic [MC-1:0] v,
                                 input logic [3:0] df, input logic [3:0] vl,
                                 input int nv, input int acc);
    exp_t       e;
    logic       all_ok;
    int         n_true;
    int         n_unres;
    int         id;
    logic [3:0] l;
    logic [2:0] u;
    e = '0;
    all_ok = 1'b1;
    e.done_cyc = acc + MC;
    for (int c = 0; c < MC; c++) begin
      if (!v[c]) continue;
      n_true = 0;
      n_unres = 0;
      u = '0;
      for (int k = 0; k < LPC; k++) begin
        l = cl[(c * LPC + k) * LW +: LW];
        id = int'(l[1:0]);
        if (!l[3] || id >= nv) continue;
        if (df[id]) begin
          if (vl[id] != l[2]) n_true++;
        end else begin
          n_unres++;
          u = l[2:0];
        end
      end
      if (n_true > 0) begin
        e.sc = e.sc + 3'd1;
      end else begin
        all_ok = 1'b0;
        if (n_unres == 0) begin
          e.rf = 1'b1;
          e.done_cyc = acc + c + 1;
          return e;
        end
        if (n_unres == 1 && !e.uf) begin
          e.uf = 1'b1;
          e.ul = u;
          e.uc = 2'(c);
        end
      end
    end
    e.rt = all_ok;
    return e;
  endfunction

  task automatic compare_out(input int d, input exp_t e, input string tag);
    check($sformatf("d%0d.%s.return_true", d, tag), rt_w[d], e.rt);
    check($sformatf("d%0d.%s.return_false", d, tag), rf_w[d], e.rf);
    check($sformatf("d%0d.%s.unit_found", d, tag), uf_w[d], e.uf);
    check($sformatf("d%0d.%s.unit_lit", d, tag), ul_w[d], e.ul);
    check($sformatf("d%0d.%s.unit_clause", d, tag), uc_w[d], e.uc);
    check($sformatf("d%0d.%s.sat_count", d, tag), sc_w[d], e.sc);
  endtask

  // Monitor: busy tracking, done timing against the scoreboard, held outputs.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        int   qs;
        logic eb;
        eb = (edge_n >= acc_e[d]) && (edge_n < end_e[d]);
        check($sformatf("d%0d.busy", d), busy_w[d], eb);
        qs = (d == 0) ? q0.size() : q1.size();
        if (done_w[d]) begin
          if (qs == 0) begin
            check($sformatf("d%0d.done_unexpected", d), done_w[d], 1'b0);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("d%0d.done_edge", d), edge_n, e.done_cyc);
            compare_out(d, e, "done");
            hold_e[d] = e;
          end
        end else begin
          if (qs > 0) begin
            e = (d == 0) ? q0[0] : q1[0];
            if (e.done_cyc <= edge_n) begin
              check($sformatf("d%0d.done_missing", d), done_w[d], 1'b1);
              if (d == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
          if (!eb) compare_out(d, hold_e[d], "hold");
        end
      end
    end
  end

  // One clock of stimulus; predicts acceptance from each instance's own busy window.
  task automatic step(input logic s);
    int   nxt;
    exp_t e;
    start = s;
    nxt = edge_n + 1;
    if (s) begin
      for (int d = 0; d < 2; d++) begin
        if (nxt >= free_e[d]) begin
          e = model(clauses, valid, def, val, (d == 0) ? 4 : 3, nxt);
          if (d == 0) q0.push_back(e);
          else        q1.push_back(e);
          acc_e[d]  = nxt;
          end_e[d]  = e.done_cyc;
          free_e[d] = e.done_cyc + 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin
        end_e[d]  = edge_n + 1;
        free_e[d] = edge_n + 2;
        hold_e[d] = '0;
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    while ((edge_n + 1 < free_e[0]) || (edge_n + 1 < free_e[1])) step(1'b0);
    step(1'b0);
  endtask

  task automatic run_case(input logic [DBW-1:0] cl, input logic [MC-1:0] v,
                          input logic [3:0] df, input logic [3:0] vl);
    clauses = cl;
    valid = v;
    def = df;
    val = vl;
    step(1'b1);
    wait_idle();
  endtask

  function automatic logic [11:0] cls(input logic [3:0] s2, input logic [3:0] s1,
                                      input logic [3:0] s0);
    return {s2, s1, s0};
  endfunction

  task automatic randomize_inputs();
    logic [3:0] l;
    for (int i = 0; i < MC * LPC; i++) begin
      l = 4'($urandom);
      l[3] = ($urandom_range(0, 3) != 0);
      clauses[i * LW +: LW] = l;
    end
    valid = 4'($urandom);
    def = 4'($urandom) | 4'($urandom);
    val = 4'($urandom);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      hold_e[d] = '0;
      acc_e[d] = 0;
      end_e[d] = 0;
      free_e[d] = 0;
    end

    // Reset, then a scan aborted by reset at E2.
    do_reset(2);
    repeat (3) step(1'b0);
    clauses = {36'h0, cls(4'h0, 4'h0, 4'h8)};
    valid = 4'b0001; def = 4'b0001; val = 4'b0001;
    step(1'b1);
    step(1'b0);
    do_reset(1);
    repeat (6) step(1'b0);

    // Directed cases.
    run_case({36'h0, cls(4'h0, 4'h0, 4'h8)}, 4'b0001, 4'b0001, 4'b0001);
    run_case({24'h0, cls(4'h0, 4'hD, 4'h8), cls(4'h0, 4'h0, 4'h8)}, 4'b0011, 4'b0011, 4'b0010);
    run_case({24'h0, cls(4'h0, 4'hD, 4'h8), cls(4'h0, 4'h0, 4'h8)}, 4'b0011, 4'b0011, 4'b0011);
    run_case({36'h0, cls(4'h0, 4'hA, 4'h8)}, 4'b0001, 4'b0001, 4'b0000);
    run_case({12'h0, cls(4'h0, 4'h0, 4'hA), 12'h0, cls(4'h0, 4'hA, 4'h8)}, 4'b0101, 4'b0001, 4'b0000);
    run_case({12'h0, cls(4'h0, 4'h0, 4'hC), 12'h0, cls(4'h0, 4'hA, 4'h8)}, 4'b0101, 4'b0000, 4'b0000);
    run_case({36'h0, cls(4'h0, 4'h0, 4'h0)}, 4'b0001, 4'b1111, 4'b0000);
    run_case({cls(4'h0, 4'h0, 4'h8), 24'h0, cls(4'h0, 4'h0, 4'h8)}, 4'b0000, 4'b0000, 4'b0000);
    run_case({36'h0, cls(4'h0, 4'h0, 4'hB)}, 4'b0001, 4'b1000, 4'b1000);
    run_case({36'h0, cls(4'hB, 4'hB, 4'h0)}, 4'b0001, 4'b0000, 4'b0000);

    // Start held for 6 cycles: second scan accepted in the done cycle.
    clauses = {36'h0, cls(4'h0, 4'h0, 4'h8)};
    valid = 4'b0001; def = 4'b0001; val = 4'b0001;
    repeat (6) step(1'b1);
    wait_idle();

    // Inputs changed after acceptance must not affect the result.
    clauses = {cls(4'h0, 4'h0, 4'h9), cls(4'h0, 4'h0, 4'hA), cls(4'h0, 4'h0, 4'h8), cls(4'hB, 4'h0, 4'h8)};
    valid = 4'b1111; def = 4'b0111; val = 4'b0101;
    step(1'b1);
    repeat (6) begin
      randomize_inputs();
      step(1'b0);
    end
    wait_idle();

    // Randomized traffic, including starts while busy.
    repeat (1500) begin
      randomize_inputs();
      step($urandom_range(0, 2) == 0);
    end
    wait_idle();
    repeat (4) step(1'b0);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
